expansion_uart_tx: RTL and testbench

- Transmit-only UART expansion card on the CPU IO bus. It sits downstream of the CPU core's IO port (ioNCE/ioAddress/ioNWE/ioNOE/bus).
- CPU writes to a data address push bytes into a small FIFO. A serializer drains the FIFO onto o_serialOut as 8N1 frames.
- A status address lets software poll for full/empty/busy/overflow before writing.
- Runs entirely on i_clk100. CPU-side strobes are asynchronous to it and are synchronized internally.

---
 rtl/expansion_uart_tx.sv | 177 +++++++++++++++++
 tb/tb_expansion_uart_tx.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/expansion_uart_tx.sv
// rtl/expansion_uart_tx.sv - transmit-only 8N1 UART card on the CPU IO bus
// Bus writes to BASE_ADDR fill a small FIFO that a baud-timed serializer drains.
`timescale 1ns/1ps
module expansion_uart_tx #(
   parameter int unsigned CLK_FREQ   = 100000000,
   parameter int unsigned BAUD       = 115200,
   parameter int unsigned FIFO_DEPTH = 4,
   parameter logic [7:0]  BASE_ADDR  = 8'h10
) (
   input  logic       i_clk100,
   input  logic       i_resetn,
   input  logic [7:0] i_bus,
   output logic [7:0] o_bus,
   output logic       o_busNOE,
   input  logic       i_ioNCE,
   input  logic [7:0] i_ioAddress,
   input  logic       i_ioNOE,
   input  logic       i_ioNWE,
   output logic       o_serialOut
);

   localparam int unsigned DIV       = CLK_FREQ / BAUD;
   localparam int unsigned AW        = $clog2(FIFO_DEPTH);
   localparam int unsigned CW        = $clog2(DIV);
   localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
   localparam logic [7:0] STAT_ADDR  = BASE_ADDR + 8'd1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_DATA  = 2'd2,
      S_STOP  = 2'd3
   } tx_state_t;

   logic          nwe_meta_q, nwe_sync_q, nwe_hist_q;
   logic          noe_meta_q, noe_sync_q, noe_hist_q;
   logic [AW:0]   wr_ptr_q, wr_ptr_d;
   logic [AW:0]   rd_ptr_q, rd_ptr_d;
   logic [7:0]    mem_q [FIFO_DEPTH];
   logic          ovf_q, ovf_d;
   logic [7:0]    status_q;
   tx_state_t     state_q;
   logic [CW-1:0] cnt_q;
   logic [2:0]    bit_q;
   logic [7:0]    shift_q;
   logic          serial_q;

   logic nwe_fall, noe_rise, sel_data, sel_stat;
   logic wr_req, push, pop, ovf_clr, full, empty;

   // CPU strobes are asynchronous to i_clk100: two sync stages plus a history flop.
   always_ff @(posedge i_clk100 or negedge i_resetn) begin
      if (!i_resetn) begin
         nwe_meta_q <= 1'b1;
         nwe_sync_q <= 1'b1;
         nwe_hist_q <= 1'b1;
         noe_meta_q <= 1'b1;
         noe_sync_q <= 1'b1;
         noe_hist_q <= 1'b1;
      end else begin
         nwe_meta_q <= i_ioNWE;
         nwe_sync_q <= nwe_meta_q;
         nwe_hist_q <= nwe_sync_q;
         noe_meta_q <= i_ioNOE;
         noe_sync_q <= noe_meta_q;
         noe_hist_q <= noe_sync_q;
      end
   end

   assign nwe_fall = nwe_hist_q & ~nwe_sync_q;
   assign noe_rise = ~noe_hist_q & noe_sync_q;
   assign sel_data = ~i_ioNCE && (i_ioAddress == BASE_ADDR);
   assign sel_stat = ~i_ioNCE && (i_ioAddress == STAT_ADDR);

   assign empty   = (wr_ptr_q == rd_ptr_q);
   assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign wr_req  = nwe_fall & sel_data;
   assign push    = wr_req & ~full;
   assign pop     = (state_q == S_IDLE) & ~empty;
   assign ovf_clr = noe_rise & sel_stat;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      ovf_d    = ovf_q;
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (ovf_clr) ovf_d = 1'b0;
      // A dropped write in the same cycle as the clearing read leaves the flag set.
      if (wr_req && full) ovf_d = 1'b1;
   end

   always_ff @(posedge i_clk100 or negedge i_resetn) begin
      if (!i_resetn) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         ovf_q    <= 1'b0;
         status_q <= 8'h00;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         ovf_q    <= ovf_d;
         status_q <= {4'b0000, ovf_q, (state_q != S_IDLE), empty, full};
      end
   end

   always_ff @(posedge i_clk100) begin
      if (push) mem_q[wr_ptr_q[AW-1:0]] <= i_bus;
   end

   // The line level is registered alongside each state change so it never glitches.
   always_ff @(posedge i_clk100 or negedge i_resetn) begin
      if (!i_resetn) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         bit_q    <= 3'd0;
         shift_q  <= 8'h00;
         serial_q <= 1'b1;
      end else begin
         case (state_q)
            S_IDLE: begin
               serial_q <= 1'b1;
               cnt_q    <= '0;
               if (!empty) begin
                  shift_q  <= mem_q[rd_ptr_q[AW-1:0]];
                  serial_q <= 1'b0;
                  state_q  <= S_START;
               end
            end
            S_START: begin
               if (cnt_q == CNT_LAST) begin
                  cnt_q    <= '0;
                  bit_q    <= 3'd0;
                  serial_q <= shift_q[0];
                  state_q  <= S_DATA;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            S_DATA: begin
               if (cnt_q == CNT_LAST) begin
                  cnt_q <= '0;
                  if (bit_q == 3'd7) begin
                     serial_q <= 1'b1;
                     state_q  <= S_STOP;
                  end else begin
                     shift_q  <= shift_q >> 1;
                     serial_q <= shift_q[1];
                     bit_q    <= bit_q + 3'd1;
                  end
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            S_STOP: begin
               serial_q <= 1'b1;
               if (cnt_q == CNT_LAST) begin
                  cnt_q   <= '0;
                  state_q <= S_IDLE;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            default: begin
               serial_q <= 1'b1;
               state_q  <= S_IDLE;
            end
         endcase
      end
   end

   assign o_serialOut = serial_q;
   assign o_bus       = status_q;
   assign o_busNOE    = ~(~i_ioNCE & ~i_ioNOE & (i_ioAddress == STAT_ADDR));

endmodule

// File: tb/tb_expansion_uart_tx.sv
// tb/tb_expansion_uart_tx.sv - scoreboard bench for expansion_uart_tx
`timescale 1ns/1ps
module tb_expansion_uart_tx;

   logic       clk = 1'b0;
   logic       rstn;
   logic [7:0] bus_i;
   logic [7:0] bus_o;
   logic       bus_noe;
   logic       nce;
   logic [7:0] addr;
   logic       noe;
   logic       nwe;
   logic       ser;

   int         n_cmp = 0;
   int         n_err = 0;
   int         noe_bad = 0;
   logic [7:0] exp_q[$];
   bit         chk_gap = 1'b0;
   logic [7:0] rd_d;
   logic       rd_noe;

   always #5 clk = ~clk;

   expansion_uart_tx #(
      .CLK_FREQ(100000000),
      .BAUD(10000000),
      .FIFO_DEPTH(4),
      .BASE_ADDR(8'h10)
   ) dut (
      .i_clk100(clk),
      .i_resetn(rstn),
      .i_bus(bus_i),
      .o_bus(bus_o),
      .o_busNOE(bus_noe),
      .i_ioNCE(nce),
      .i_ioAddress(addr),
      .i_ioNOE(noe),
      .i_ioNWE(nwe),
      .o_serialOut(ser)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic do_write(input logic [7:0] a, input logic [7:0] d, input int hold);
      @(negedge clk);
      nce = 1'b0; addr = a; bus_i = d; nwe = 1'b0;
      repeat (hold) @(negedge clk);
      nwe = 1'b1;
      repeat (3) @(negedge clk);
      nce = 1'b1; addr = 8'h00; bus_i = 8'h00;
   endtask

   task automatic do_read(input logic [7:0] a, output logic [7:0] d, output logic n);
      @(negedge clk);
      nce = 1'b0; addr = a; noe = 1'b0;
      repeat (2) @(negedge clk);
      d = bus_o;
      n = bus_noe;
      noe = 1'b1;
      repeat (4) @(negedge clk);
      nce = 1'b1; addr = 8'h00;
   endtask

   task automatic wait_drain();
      for (int i = 0; i < 3000 && exp_q.size() != 0; i++) @(negedge clk);
      check("drain_timeout", exp_q.size(), 0);
      repeat (120) @(negedge clk);
   endtask

   always @(negedge clk) begin
      if (rstn && bus_noe == 1'b0 && !(nce == 1'b0 && noe == 1'b0 && addr == 8'h11))
         noe_bad++;
   end

   // Monitor: decodes every frame on the line and scores it against the expected queue.
   initial begin
      int         t;
      int         t_s;
      int         last_end;
      logic       prev;
      bit         have_prev;
      bit         aborted;
      bit         ok;
      logic [7:0] b;
      logic       s [100];
      t = 0; last_end = 0; prev = 1'b1; have_prev = 1'b0;
      forever begin
         @(negedge clk);
         t++;
         if (!chk_gap) have_prev = 1'b0;
         if (rstn && prev && !ser) begin
            t_s = t;
            aborted = 1'b0;
            s[0] = ser;
            for (int i = 1; i < 100; i++) begin
               @(negedge clk);
               t++;
               if (!rstn) begin
                  aborted = 1'b1;
                  break;
               end
               s[i] = ser;
            end
            if (!aborted) begin
               ok = 1'b1;
               for (int k = 0; k < 10; k++)
                  for (int j = 0; j < 10; j++)
                     if (s[k*10+j] !== s[k*10]) ok = 1'b0;
               if (s[0] !== 1'b0 || s[90] !== 1'b1) ok = 1'b0;
               for (int k = 0; k < 8; k++) b[k] = s[(k+1)*10];
               if (exp_q.size() == 0) begin
                  n_cmp++;
                  n_err++;
                  $display("FAIL frame_unexpected: got 0x%0h, expected no frame", b);
               end else begin
                  check("frame", {23'd0, ok, b}, {23'd0, 1'b1, exp_q.pop_front()});
               end
               if (chk_gap && have_prev) check("frame_gap", t_s - last_end - 1, 1);
               have_prev = 1'b1;
               last_end = t;
            end
            prev = 1'b1;
         end else begin
            prev = ser;
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1);
   end

   initial begin
      rstn = 1'b0; nce = 1'b1; noe = 1'b1; nwe = 1'b1; addr = 8'h00; bus_i = 8'h00;
      repeat (3) @(negedge clk);
      check("reset_line", ser, 1);
      check("reset_busnoe", bus_noe, 1);
      check("reset_bus", bus_o, 8'h00);
      rstn = 1'b1;
      repeat (5) @(negedge clk);
      do_read(8'h11, rd_d, rd_noe);
      check("idle_status", rd_d, 8'h02);
      check("status_read_drive", rd_noe, 0);

      // single 0xA5 frame with start-bit latency check
      @(negedge clk);
      nce = 1'b0; addr = 8'h10; bus_i = 8'hA5; nwe = 1'b0;
      exp_q.push_back(8'hA5);
      repeat (3) @(negedge clk);
      check("latency_pre_start", ser, 1);
      @(negedge clk);
      check("latency_start", ser, 0);
      nwe = 1'b1;
      repeat (3) @(negedge clk);
      nce = 1'b1; addr = 8'h00; bus_i = 8'h00;
      do_read(8'h11, rd_d, rd_noe);
      check("busy_status", rd_d, 8'h06);
      wait_drain();
      do_read(8'h11, rd_d, rd_noe);
      check("after_frame_status", rd_d, 8'h02);

      // burst: one byte in the shifter plus four queued, sixth write overflows
      chk_gap = 1'b1;
      for (int i = 1; i <= 6; i++) begin
         do_write(8'h10, 8'(i), 3);
         if (i <= 5) exp_q.push_back(8'(i));
      end
      do_read(8'h11, rd_d, rd_noe);
      check("overflow_status", rd_d, 8'h0D);
      do_read(8'h11, rd_d, rd_noe);
      check("overflow_cleared", rd_d, 8'h05);
      wait_drain();
      chk_gap = 1'b0;

      // long write pulse yields exactly one frame
      do_write(8'h10, 8'h3C, 50);
      exp_q.push_back(8'h3C);
      wait_drain();

      // undecoded accesses
      do_write(8'h12, 8'h55, 3);
      do_read(8'h10, rd_d, rd_noe);
      check("data_addr_read_drive", rd_noe, 1);
      repeat (150) @(negedge clk);
      check("no_frame_line", ser, 1);

      // reset during the DATA phase of 0x11 with three bytes queued
      do_write(8'h10, 8'h11, 3);
      do_write(8'h10, 8'h22, 3);
      do_write(8'h10, 8'h33, 3);
      do_write(8'h10, 8'h44, 3);
      exp_q.push_back(8'h11);
      exp_q.push_back(8'h22);
      exp_q.push_back(8'h33);
      exp_q.push_back(8'h44);
      repeat (12) @(negedge clk);
      check("mid_frame_low", ser, 0);
      rstn = 1'b0;
      #1;
      check("reset_abort_line", ser, 1);
      exp_q.delete();
      repeat (3) @(negedge clk);
      rstn = 1'b1;
      repeat (3) @(negedge clk);
      do_read(8'h11, rd_d, rd_noe);
      check("post_reset_status", rd_d, 8'h02);
      repeat (300) @(negedge clk);
      check("post_reset_line", ser, 1);
      check("busnoe_spurious", noe_bad, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
